warp_issue_scheduler: RTL and testbench

WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

---
 rtl/warp_issue_scheduler_pkg.sv | 18 +
 rtl/warp_issue_scheduler_if.sv | 39 +++
 rtl/warp_issue_scheduler_rr_pick.sv | 34 +++
 rtl/warp_issue_scheduler.sv | 153 +++++++++++++++
 tb/tb_warp_issue_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/warp_issue_scheduler_pkg.sv
// Shared types and constants for the warp issue scheduler.
// WARP_SCHED_PERF_EN (optional macro) enables the perf counters, which are
// perf_cnt_w bits wide.
package warp_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    localparam int unsigned perf_cnt_w = 32;

    // Cooldown counter width: enough to hold cool_cycles, never below 1 bit.
    function automatic int unsigned cool_width(input int unsigned cool_cycles);
        return (cool_cycles < 1) ? 1 : $clog2(cool_cycles + 1);
    endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Issue-side bundle of the warp issue scheduler.
// master = scheduler, slave = warp sources / downstream issue stage.
// WARP_SCHED_PERF_EN adds issue_cnt_o and stall_cnt_o.
interface warp_issue_scheduler_if #(
    parameter int NumWarps = 8
);
    import warp_sched_pkg::*;

    localparam int IdxW = $clog2(NumWarps);

    logic [NumWarps-1:0] warp_rdy_i;
    logic [NumWarps-1:0] en_mask_i;
    logic                flush_i;
    logic                issue_ready_i;
    logic                issue_valid_o;
    logic [NumWarps-1:0] grnt_o;
    logic [IdxW-1:0]     grnt_idx_o;
`ifdef WARP_SCHED_PERF_EN
    logic [perf_cnt_w-1:0] issue_cnt_o;
    logic [perf_cnt_w-1:0] stall_cnt_o;
`endif

    modport master (
        input  warp_rdy_i, en_mask_i, flush_i, issue_ready_i,
`ifdef WARP_SCHED_PERF_EN
        output issue_cnt_o, stall_cnt_o,
`endif
        output issue_valid_o, grnt_o, grnt_idx_o
    );

    modport slave (
        output warp_rdy_i, en_mask_i, flush_i, issue_ready_i,
`ifdef WARP_SCHED_PERF_EN
        input  issue_cnt_o, stall_cnt_o,
`endif
        input  issue_valid_o, grnt_o, grnt_idx_o
    );

endinterface

// File: rtl/warp_issue_scheduler_rr_pick.sv
// Round-robin picker: first eligible warp scanning last_ptr+1, last_ptr+2, ...
// with wrap-around. Purely combinational.
module rr_pick #(
    parameter int NumWarps = 8
) (
    input  logic [NumWarps-1:0]         elig,
    input  logic [$clog2(NumWarps)-1:0] last_ptr,
    output logic [NumWarps-1:0]         pick_oh,
    output logic [$clog2(NumWarps)-1:0] pick_idx,
    output logic                        pick_any
);

    localparam int IdxW = $clog2(NumWarps);

    logic [IdxW-1:0] cand;

    // Scan farthest offset first so the nearest eligible warp is the last write.
    // NumWarps is a power of two, so the index sum wraps naturally.
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int k = NumWarps; k >= 1; k--) begin
            cand = last_ptr + IdxW'(k);
            if (elig[cand]) begin
                pick_idx = cand;
                pick_any = 1'b1;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = pick_any;
    end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: round-robin grant among ready, enabled, cooled-down
// warps, held stable until downstream accepts.
// WARP_SCHED_PERF_EN (optional macro) adds accepted-issue and stall counters.
//
//   state | meaning
//   IDLE  | no grant presented; registers a pick when any warp is eligible
//   GRANT | grant presented and held until accepted; back-to-back re-pick
module warp_issue_scheduler
    import warp_sched_pkg::*;
#(
    parameter int NumWarps   = 8,
    parameter int CoolCycles = 4
) (
    input logic                    clk,
    input logic                    rst,
    warp_issue_scheduler_if.master bus
);

    localparam int              IdxW      = $clog2(NumWarps);
    localparam int              CoolW     = cool_width(CoolCycles);
    localparam logic [CoolW-1:0] cool_load = CoolW'(CoolCycles);
    localparam logic [0:0]      st_idle   = 1'(IDLE);
    localparam logic [0:0]      st_grant  = 1'(GRANT);

    logic [0:0]          state_q;
    logic [NumWarps-1:0] grnt_q;
    logic [IdxW-1:0]     grnt_idx_q;
    logic [IdxW-1:0]     last_ptr_q;
    logic [CoolW-1:0]    cool_cnt_q [NumWarps];

    logic [NumWarps-1:0] elig;
    logic [NumWarps-1:0] pick_elig;
    logic [IdxW-1:0]     pick_ptr;
    logic [NumWarps-1:0] pick_oh;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_any;
    logic                accept;

    assign accept = (state_q == st_grant) && bus.issue_ready_i;

    // Eligibility: ready, enabled and cooldown expired.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NumWarps; i++) begin
            elig[i] = bus.warp_rdy_i[i] & bus.en_mask_i[i] & (cool_cnt_q[i] == '0);
        end
    end

    // On acceptance, re-pick as if the accepted warp were already last_ptr and
    // already cooling, so back-to-back grants never repeat the same warp.
    always_comb begin
        pick_elig = elig;
        pick_ptr  = last_ptr_q;
        if (accept) begin
            pick_elig = elig & ~grnt_q;
            pick_ptr  = grnt_idx_q;
        end
    end

    rr_pick #(
        .NumWarps (NumWarps)
    ) u_rr_pick (
        .elig     (pick_elig),
        .last_ptr (pick_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // Grant FSM; flush drops the grant and discards a same-cycle acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= st_idle;
            grnt_q     <= '0;
            grnt_idx_q <= '0;
            last_ptr_q <= IdxW'(NumWarps - 1);
        end else if (bus.flush_i) begin
            state_q    <= st_idle;
            grnt_q     <= '0;
            grnt_idx_q <= '0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (pick_any) begin
                        state_q    <= st_grant;
                        grnt_q     <= pick_oh;
                        grnt_idx_q <= pick_idx;
                    end
                end
                default: begin
                    if (accept) begin
                        last_ptr_q <= grnt_idx_q;
                        if (pick_any) begin
                            grnt_q     <= pick_oh;
                            grnt_idx_q <= pick_idx;
                        end else begin
                            state_q    <= st_idle;
                            grnt_q     <= '0;
                            grnt_idx_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

    // Per-warp cooldown down-counters; a load on acceptance wins over decrement.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            for (int i = 0; i < NumWarps; i++) begin
                cool_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumWarps; i++) begin
                if (accept && (grnt_idx_q == IdxW'(i))) begin
                    cool_cnt_q[i] <= cool_load;
                end else if (cool_cnt_q[i] != '0) begin
                    cool_cnt_q[i] <= cool_cnt_q[i] - CoolW'(1);
                end
            end
        end
    end

    assign bus.issue_valid_o = (state_q == st_grant);
    assign bus.grnt_o        = grnt_q;
    assign bus.grnt_idx_o    = grnt_idx_q;

`ifdef WARP_SCHED_PERF_EN
    logic [perf_cnt_w-1:0] issue_cnt_q;
    logic [perf_cnt_w-1:0] stall_cnt_q;

    // Wrapping perf counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && !bus.flush_i) begin
                issue_cnt_q <= issue_cnt_q + perf_cnt_w'(1);
            end
            if ((state_q == st_grant) && !bus.issue_ready_i) begin
                stall_cnt_q <= stall_cnt_q + perf_cnt_w'(1);
            end
        end
    end

    assign bus.issue_cnt_o = issue_cnt_q;
    assign bus.stall_cnt_o = stall_cnt_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler. Two instances share the stimulus:
// dut4 (CoolCycles=4) and dut0 (CoolCycles=0, cooldown disabled).
// Perf counter checks are compiled only with WARP_SCHED_PERF_EN.
module tb_warp_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rdy;
    logic [7:0] en;
    logic       flush;
    logic       ready;

    int n_vec = 0;
    int n_err = 0;

    warp_issue_scheduler_if #(.NumWarps(8)) bus4 ();
    warp_issue_scheduler_if #(.NumWarps(8)) bus0 ();

    assign bus4.warp_rdy_i    = rdy;
    assign bus4.en_mask_i     = en;
    assign bus4.flush_i       = flush;
    assign bus4.issue_ready_i = ready;
    assign bus0.warp_rdy_i    = rdy;
    assign bus0.en_mask_i     = en;
    assign bus0.flush_i       = flush;
    assign bus0.issue_ready_i = ready;

    warp_issue_scheduler #(.NumWarps(8), .CoolCycles(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    warp_issue_scheduler #(.NumWarps(8), .CoolCycles(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        rdy   = 8'h00;
        en    = 8'hFF;
        flush = 1'b0;
        ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rdy   = 8'hFF;
        en    = 8'hFF;
        flush = 1'b0;
        ready = 1'b1;
        step();
        n_vec++;
        if ({bus4.issue_valid_o, bus4.grnt_o, bus4.grnt_idx_o} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut4: got v=%b g=%h i=%0d expected all zero",
                     bus4.issue_valid_o, bus4.grnt_o, bus4.grnt_idx_o);
        end
        n_vec++;
        if ({bus0.issue_valid_o, bus0.grnt_o, bus0.grnt_idx_o} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_dut0: got v=%b g=%h i=%0d expected all zero",
                     bus0.issue_valid_o, bus0.grnt_o, bus0.grnt_idx_o);
        end
`ifdef WARP_SCHED_PERF_EN
        n_vec++;
        if ({bus4.issue_cnt_o, bus4.stall_cnt_o} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_perf: got issue=%0d stall=%0d expected 0 0",
                     bus4.issue_cnt_o, bus4.stall_cnt_o);
        end
`endif
    endtask

    // All warps ready, always accepted: 0,1,...,7,0 after one cycle latency.
    // A cooldown of 4 never bites here since each warp returns 8 cycles later.
    task automatic test_round_robin();
        logic [7:0] e_oh;
        logic [2:0] e_idx;
        apply_reset();
        rdy   = 8'hFF;
        ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            e_idx = 3'(i % 8);
            e_oh  = 8'h01 << e_idx;
            n_vec++;
            if (bus0.issue_valid_o !== 1'b1 || bus0.grnt_o !== e_oh || bus0.grnt_idx_o !== e_idx) begin
                n_err++;
                $display("FAIL rr_dut0[%0d]: got v=%b g=%h i=%0d expected v=1 g=%h i=%0d",
                         i, bus0.issue_valid_o, bus0.grnt_o, bus0.grnt_idx_o, e_oh, e_idx);
            end
            n_vec++;
            if (bus4.grnt_o !== e_oh || bus4.grnt_idx_o !== e_idx) begin
                n_err++;
                $display("FAIL rr_dut4[%0d]: got g=%h i=%0d expected g=%h i=%0d",
                         i, bus4.grnt_o, bus4.grnt_idx_o, e_oh, e_idx);
            end
        end
    endtask

    // Warps 2 and 5 ready, downstream stalls 5 cycles: warp 2 held, then warp 5.
    task automatic test_hold_stall();
        apply_reset();
        rdy   = 8'h24;
        ready = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            n_vec++;
            if (bus4.grnt_o !== 8'h04 || bus4.issue_valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL hold_grant[%0d]: got v=%b g=%h expected v=1 g=04",
                         c, bus4.issue_valid_o, bus4.grnt_o);
            end
        end
`ifdef WARP_SCHED_PERF_EN
        n_vec++;
        if (bus4.stall_cnt_o !== 32'd5) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d expected 5", bus4.stall_cnt_o);
        end
`endif
        ready = 1'b1;
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h20 || bus4.grnt_idx_o !== 3'd5) begin
            n_err++;
            $display("FAIL hold_next: got g=%h i=%0d expected g=20 i=5", bus4.grnt_o, bus4.grnt_idx_o);
        end
        n_vec++;
        if (bus0.grnt_o !== 8'h20) begin
            n_err++;
            $display("FAIL hold_next_dut0: got g=%h expected g=20", bus0.grnt_o);
        end
    endtask

    // Only warp 3 ready. dut4: accepted in cycle 1, ineligible for 4 cycles,
    // re-picked in cycle 6 and presented in cycle 7. dut0 re-presents in cycle 3.
    task automatic test_cooldown();
        apply_reset();
        rdy   = 8'h08;
        ready = 1'b1;
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h08 || bus4.issue_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL cool_first: got v=%b g=%h expected v=1 g=08", bus4.issue_valid_o, bus4.grnt_o);
        end
        for (int c = 2; c <= 6; c++) begin
            step();
            n_vec++;
            if (bus4.issue_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL cool_gap[%0d]: got v=%b expected v=0", c, bus4.issue_valid_o);
            end
            if (c == 2) begin
                n_vec++;
                if (bus0.issue_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL nocool_gap: got v=%b expected v=0", bus0.issue_valid_o);
                end
            end
            if (c == 3) begin
                n_vec++;
                if (bus0.issue_valid_o !== 1'b1 || bus0.grnt_o !== 8'h08) begin
                    n_err++;
                    $display("FAIL nocool_regrant: got v=%b g=%h expected v=1 g=08",
                             bus0.issue_valid_o, bus0.grnt_o);
                end
            end
        end
        step();
        n_vec++;
        if (bus4.issue_valid_o !== 1'b1 || bus4.grnt_o !== 8'h08) begin
            n_err++;
            $display("FAIL cool_regrant: got v=%b g=%h expected v=1 g=08", bus4.issue_valid_o, bus4.grnt_o);
        end
    endtask

    // Warp 5 accepted, warp 6 pending; flush with ready in the same cycle.
    // With warps 0 and 6 ready afterwards, last_ptr=5 selects warp 6.
    task automatic test_flush();
        apply_reset();
        rdy   = 8'h60;
        ready = 1'b1;
        step();
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h40 || bus4.grnt_idx_o !== 3'd6) begin
            n_err++;
            $display("FAIL flush_setup: got g=%h i=%0d expected g=40 i=6", bus4.grnt_o, bus4.grnt_idx_o);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_vec++;
        if ({bus4.issue_valid_o, bus4.grnt_o, bus4.grnt_idx_o} !== 12'h000) begin
            n_err++;
            $display("FAIL flush_drop: got v=%b g=%h i=%0d expected all zero",
                     bus4.issue_valid_o, bus4.grnt_o, bus4.grnt_idx_o);
        end
`ifdef WARP_SCHED_PERF_EN
        n_vec++;
        if (bus4.issue_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL flush_issue_cnt: got %0d expected 1", bus4.issue_cnt_o);
        end
`endif
        rdy = 8'h41;
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h40 || bus4.grnt_idx_o !== 3'd6) begin
            n_err++;
            $display("FAIL flush_lastptr: got g=%h i=%0d expected g=40 i=6", bus4.grnt_o, bus4.grnt_idx_o);
        end
        n_vec++;
        if (bus0.grnt_o !== 8'h40) begin
            n_err++;
            $display("FAIL flush_lastptr_dut0: got g=%h expected g=40", bus0.grnt_o);
        end

        // Flush also clears a running cooldown: warp 3 returns two cycles later.
        apply_reset();
        rdy   = 8'h08;
        ready = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_vec++;
        if (bus4.issue_valid_o !== 1'b1 || bus4.grnt_o !== 8'h08) begin
            n_err++;
            $display("FAIL flush_cool_clear: got v=%b g=%h expected v=1 g=08", bus4.issue_valid_o, bus4.grnt_o);
        end
    endtask

    // Warp 2 granted, then masked off: grant held, later picks skip warp 2.
    task automatic test_mask_hold();
        apply_reset();
        rdy   = 8'h0C;
        ready = 1'b0;
        step();
        en = 8'hFB;
        step();
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h04 || bus4.issue_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL mask_hold: got v=%b g=%h expected v=1 g=04", bus4.issue_valid_o, bus4.grnt_o);
        end
        ready = 1'b1;
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h08 || bus4.grnt_idx_o !== 3'd3) begin
            n_err++;
            $display("FAIL mask_next: got g=%h i=%0d expected g=08 i=3", bus4.grnt_o, bus4.grnt_idx_o);
        end
        step();
        n_vec++;
        if (bus0.issue_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL mask_idle_dut0: got v=%b expected v=0", bus0.issue_valid_o);
        end
        step();
        n_vec++;
        if (bus0.grnt_o !== 8'h08 || bus0.issue_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL mask_skip_dut0: got v=%b g=%h expected v=1 g=08", bus0.issue_valid_o, bus0.grnt_o);
        end
    endtask

    // Reset during a held grant on warp 5 (with flush and ready also high)
    // drops everything; the next pick restarts at warp 4, the lowest eligible.
    task automatic test_reset_mid_grant();
        apply_reset();
        rdy   = 8'h30;
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h20) begin
            n_err++;
            $display("FAIL rstmid_setup: got g=%h expected g=20", bus4.grnt_o);
        end
        rst   = 1'b1;
        flush = 1'b1;
        ready = 1'b1;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        n_vec++;
        if ({bus4.issue_valid_o, bus4.grnt_o, bus4.grnt_idx_o} !== 12'h000) begin
            n_err++;
            $display("FAIL rstmid_drop: got v=%b g=%h i=%0d expected all zero",
                     bus4.issue_valid_o, bus4.grnt_o, bus4.grnt_idx_o);
        end
        step();
        n_vec++;
        if (bus4.grnt_o !== 8'h10 || bus4.grnt_idx_o !== 3'd4) begin
            n_err++;
            $display("FAIL rstmid_regrant: got g=%h i=%0d expected g=10 i=4", bus4.grnt_o, bus4.grnt_idx_o);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold_stall();
        test_cooldown();
        test_flush();
        test_mask_hold();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
